set_assoc_dcache: RTL

//  Parametrised 2-way set-associative, write-through, no-write-allocate data cache.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_way.sv | 56 +++++
 rtl/set_assoc_dcache.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the 2-way set-associative data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REFILL = 2'd1,
      WRITE  = 2'd2
   } dcache_state_t;

   // One-hot byte enable for a byte access at the given byte offset.
   function automatic logic [3:0] byte_lane_be(input logic [1:0] off);
      return 4'b0001 << off;
   endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/tag/data storage with a combinational lookup port and
// a synchronous port that either fills a whole line or merges a store.
module dcache_way
   import dcache_pkg::*;
#(
   parameter int SET_W      = 3,
   parameter int WOFF_W     = 2,
   parameter int TAG_W      = 25,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [SET_W-1:0]                 set_idx,
   input  logic [WOFF_W-1:0]                word_idx,
   input  logic [TAG_W-1:0]                 tag,
   output logic                             hit,
   output logic [DATA_WIDTH-1:0]            rd_data,
   input  logic                             fill_en,
   input  logic [(DATA_WIDTH<<WOFF_W)-1:0]  fill_line,
   input  logic                             wr_en,
   input  logic [3:0]                       wr_be,
   input  logic [DATA_WIDTH-1:0]            wr_data
);

   localparam int SETS  = 1 << SET_W;
   localparam int WORDS = 1 << WOFF_W;

   logic                  valid_q [SETS];
   logic [TAG_W-1:0]      tag_q   [SETS];
   logic [DATA_WIDTH-1:0] data_q  [SETS][WORDS];

   assign hit     = valid_q[set_idx] && (tag_q[set_idx] == tag);
   assign rd_data = data_q[set_idx][word_idx];

   // Valid bits: cleared by reset, set only when a complete line lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++) valid_q[s] <= 1'b0;
      end else if (fill_en) begin
         valid_q[set_idx] <= 1'b1;
      end
   end

   // Tag/data storage: whole-line fill, or byte-masked merge of a store hit.
   always_ff @(posedge clk) begin
      if (fill_en) begin
         tag_q[set_idx] <= tag;
         for (int w = 0; w < WORDS; w++)
            data_q[set_idx][w] <= fill_line[w*DATA_WIDTH +: DATA_WIDTH];
      end else if (wr_en) begin
         for (int b = 0; b < 4; b++)
            if (wr_be[b]) data_q[set_idx][word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

endmodule

// File: rtl/set_assoc_dcache.sv
// 2-way set-associative, write-through, no-write-allocate data cache.
//
// state  | meaning
// IDLE   | serve load hits combinationally, launch refill or store
// REFILL | fetch the block one word per beat, stall the pipeline
// WRITE  | forward a store to memory, release stall on mem_ready
module set_assoc_dcache
   import dcache_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int SETS            = 8,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic                  req_byte,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int SET_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_WIDTH - SET_W - WOFF_W - 2;
   localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(WORDS_PER_BLOCK - 1);

   logic [1:0]        byte_off;
   logic [WOFF_W-1:0] word_idx;
   logic [SET_W-1:0]  set_idx;
   logic [TAG_W-1:0]  tag;

   assign byte_off = req_addr[1:0];
   assign word_idx = req_addr[WOFF_W+1:2];
   assign set_idx  = req_addr[SET_W+WOFF_W+1:WOFF_W+2];
   assign tag      = req_addr[ADDR_WIDTH-1:SET_W+WOFF_W+2];

   dcache_state_t         state;
   logic [WOFF_W-1:0]     count;
   logic [SETS-1:0]       lru;
   logic [DATA_WIDTH-1:0] line_buf [WORDS_PER_BLOCK];
   logic [(DATA_WIDTH<<WOFF_W)-1:0] fill_line;

   logic                  hit0, hit1, hit, hit_way, victim;
   logic [DATA_WIDTH-1:0] rd0, rd1, hit_word, load_data;
   logic                  last_beat, store_hit;
   logic [3:0]            store_be;
   logic [DATA_WIDTH-1:0] store_data;

   // Way0 wins if both ways ever claim the same tag.
   assign hit       = hit0 | hit1;
   assign hit_way   = ~hit0;
   assign hit_word  = hit0 ? rd0 : rd1;
   assign load_data = req_byte ? {{(DATA_WIDTH-8){1'b0}}, hit_word[{byte_off, 3'b000} +: 8]}
                               : hit_word;
   assign victim    = lru[set_idx];
   assign last_beat = (state == REFILL) && mem_ready && (count == LAST_BEAT);
   assign store_hit = (state == IDLE) && req_valid && req_we && hit;
   assign store_be  = req_byte ? byte_lane_be(byte_off) : 4'b1111;
   assign store_data = req_byte ? {4{req_wdata[7:0]}} : req_wdata;

   dcache_way #(.SET_W(SET_W), .WOFF_W(WOFF_W), .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)) u_way0 (
      .clk(clk), .rst(rst), .set_idx(set_idx), .word_idx(word_idx), .tag(tag),
      .hit(hit0), .rd_data(rd0),
      .fill_en(last_beat && !victim), .fill_line(fill_line),
      .wr_en(store_hit && hit0), .wr_be(store_be), .wr_data(store_data)
   );

   dcache_way #(.SET_W(SET_W), .WOFF_W(WOFF_W), .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)) u_way1 (
      .clk(clk), .rst(rst), .set_idx(set_idx), .word_idx(word_idx), .tag(tag),
      .hit(hit1), .rd_data(rd1),
      .fill_en(last_beat && victim), .fill_line(fill_line),
      .wr_en(store_hit && !hit0), .wr_be(store_be), .wr_data(store_data)
   );

   // The final beat bypasses the buffer so the line is written on the beat it arrives.
   always_comb begin
      fill_line = '0;
      for (int w = 0; w < WORDS_PER_BLOCK; w++)
         fill_line[w*DATA_WIDTH +: DATA_WIDTH] = (w == WORDS_PER_BLOCK - 1) ? mem_rdata : line_buf[w];
   end

   // Collect refill beats in word order.
   always_ff @(posedge clk) begin
      if (state == REFILL && mem_ready) line_buf[count] <= mem_rdata;
   end

   // Controller state, beat counter and per-set LRU bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         count <= '0;
         lru   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_we) begin
                     state <= WRITE;
                  end else if (hit) begin
                     lru[set_idx] <= ~hit_way;
                  end else begin
                     state <= REFILL;
                     count <= '0;
                  end
               end
            end
            REFILL: begin
               if (mem_ready) begin
                  count <= count + 1'b1;
                  if (count == LAST_BEAT) begin
                     lru[set_idx] <= ~victim;
                     state        <= IDLE;
                  end
               end
            end
            WRITE: begin
               if (mem_ready) state <= WRITE == state ? IDLE : state;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Outputs follow the registered state; request fields are held by the CPU while stalled.
   always_comb begin
      rdata     = '0;
      stall     = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = 4'b0000;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!req_we && hit) rdata = load_data;
               else                stall = 1'b1;
            end
         end
         REFILL: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = {tag, set_idx, count, 2'b00};
         end
         WRITE: begin
            stall     = !mem_ready;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be    = store_be;
            mem_wdata = store_data;
         end
         default: ;
      endcase
   end

endmodule
